bitset_cmd_seq: RTL and testbench
=================================

Name: bitset_cmd_seq

Overview:
- Sequential front end that holds a WIDTH-bit word and applies queued single-bit write commands to it.
- Each command uses the same index/value rule as the bitset stage: y[index] <= value, all other bits unchanged.
- Commands arrive over a valid/ready handshake into a small FIFO. One command is applied per cycle.
- The registered word y drives the downstream consumer, with a one-cycle update pulse.

Parameters:
- WIDTH, 4, data word width in bits.
- IDX_W, 2, command index width; must satisfy 2**IDX_W >= WIDTH.
- DEPTH, 4, command FIFO depth (power of two, >= 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_load  input  1  1 = whole-word load of cmd_data; 0 = single-bit write.
- cmd_index  input  IDX_W  bit position for a single-bit write.
- cmd_value  input  1  bit value for a single-bit write.
- cmd_data  input  WIDTH  word for a load command.
- hold  input  1  freeze command consumption.
- y  output  WIDTH  current word.
- y_valid  output  1  one-cycle pulse: y was updated by a command on the previous edge.
- idx_err  output  1  sticky flag: a command with cmd_index >= WIDTH was consumed.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- busy  output  1  FIFO non-empty or in HOLD with pending commands.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - y = 0, y_valid = 0, idx_err = 0, count = 0, FIFO pointers = 0, state = IDLE.
  - cmd_ready = 1 once rst_n is high.
- Handshake:
  - Push on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = (count < DEPTH); it is combinational from count only, never from cmd_valid.
  - A full FIFO gives cmd_ready = 0; no push occurs even if a pop happens that cycle.
  - The payload is sampled only at the push edge.
- States:
  - IDLE: FIFO empty. Push -> RUN.
  - RUN: on each edge with count > 0, pop the head and apply it.
    - hold = 1 -> HOLD.
    - Last entry popped with no simultaneous push -> IDLE.
  - HOLD: no pops; pushes still accepted while not full. hold = 0 -> RUN if count > 0, else IDLE.
- Apply rules (on the pop edge):
  - load: y <= cmd_data.
  - single-bit, index < WIDTH: y[index] <= value, other bits unchanged.
  - single-bit, index >= WIDTH: y unchanged, idx_err <= 1. The command is still consumed and y_valid still pulses.
- y_valid:
  - High for exactly one cycle after each pop edge.
  - Back-to-back pops keep it high continuously.
- Latency:
  - Command pushed at edge N into an empty FIFO with hold = 0 is popped at edge N+1.
  - New y and y_valid are visible after edge N+1.
  - Minimum 1 cycle, push to y update.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full/empty are distinguished by count, not by pointer equality.
- y holds its value indefinitely when no pop occurs.
- idx_err clears only on reset.
- Reset mid-operation: all queued commands are discarded. y returns to 0 without a y_valid pulse.
- busy = (count != 0).

Optional Feature:
- Macro: BITSET_PARITY_EN.
- Defined: adds output y_parity (1 bit) = XOR of all bits of y. It is registered together with y, so it is coherent with y in every cycle; reset value 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then single command load=1 data=1100 → after 1 cycle y=1100, y_valid pulse, idx_err=0.
- Two consecutive pushes, then an idle cycle:
  - Commands: bit write index=00 value=1, then index=10 value=0, starting from y=0101.
  - Consecutive cycles: y=0101 → 0101 → 0001, y_valid high for 2 cycles.
  - Idle cycle after: y_valid=0.
- Hold behaviour:
  - With hold=1, push 4 commands: count=4, cmd_ready=0.
  - A 5th cmd_valid is not accepted.
  - Release hold: 4 pops on consecutive cycles, count → 0, state returns to IDLE, cmd_ready=1 after the first pop.
- Simultaneous push/pop at count=2 → count stays 2. Issue 8+ commands so pointers wrap; the y sequence matches the in-order application model.
- WIDTH=3 instance, bit write index=11 value=1 with y=101 → y stays 101, y_valid pulses, idx_err=1 and remains 1.
- Assert rst_n low asynchronously (between edges) with count=3 and y=1111 → y=0 and count=0 immediately. No pops after release; cmd_ready=1.
- With BITSET_PARITY_EN: loads 1100 then 0111 → y_parity 0 then 1, aligned with y.

Source files
------------

// File: rtl/bitset_cmd_seq.sv
// ============================================================================
// Module  : bitset_cmd_seq
// Brief   : Queued single-bit / whole-word write front end with a registered word.
//           Optional macro BITSET_PARITY_EN adds a y_parity output coherent with y.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bitset_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_load,
  input  logic [IDX_W-1:0]         cmd_index,
  input  logic                     cmd_value,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic                     hold,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid,
  output logic                     idx_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
`ifdef BITSET_PARITY_EN
  ,
  output logic                     y_parity
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + IDX_W + 1 + WIDTH;
  localparam logic [CW-1:0]    c_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]    c_ONE   = CW'(1);
  localparam logic [IDX_W:0]   c_WIDTH = (IDX_W + 1)'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             r_state;
  logic [EW-1:0]      r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_y;
  logic               r_y_valid;
  logic               r_idx_err;

  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic [EW-1:0]      w_head;
  logic               w_head_load;
  logic [IDX_W-1:0]   w_head_index;
  logic               w_head_value;
  logic [WIDTH-1:0]   w_head_data;
  logic               w_idx_ok;
  logic [WIDTH-1:0]   w_y_next;

  // Ready depends on occupancy only, so a pop in the same cycle never frees a full FIFO.
  assign w_ready = (r_count < c_DEPTH);
  assign w_push  = cmd_valid && w_ready;
  assign w_pop   = (r_state == S_RUN) && (r_count != '0) && !hold;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_load  = w_head[EW-1];
  assign w_head_index = w_head[EW-2 -: IDX_W];
  assign w_head_value = w_head[WIDTH];
  assign w_head_data  = w_head[WIDTH-1:0];
  assign w_idx_ok     = ({1'b0, w_head_index} < c_WIDTH);

  // Out-of-range indices simply match no bit, leaving the word untouched.
  always_comb begin
    w_y_next = r_y;
    if (w_head_load) begin
      w_y_next = w_head_data;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ({1'b0, w_head_index} == (IDX_W + 1)'(i)) begin
          w_y_next[i] = w_head_value;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_load, cmd_index, cmd_value, cmd_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_idx_err <= 1'b0;
    end else begin
      r_y_valid <= w_pop;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_y      <= w_y_next;
        if (!w_head_load && !w_idx_ok) begin
          r_idx_err <= 1'b1;
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_push || (r_count != '0)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (hold) begin
            r_state <= S_HOLD;
          end else if (!w_push && ((r_count == '0) || (w_pop && (r_count == c_ONE)))) begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (!hold) begin
            r_state <= ((r_count != '0) || w_push) ? S_RUN : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BITSET_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^w_y_next;
    end
  end

  assign y_parity = r_parity;
`endif

  assign cmd_ready = w_ready;
  assign y         = r_y;
  assign y_valid   = r_y_valid;
  assign idx_err   = r_idx_err;
  assign count     = r_count;
  assign busy      = (r_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_bitset_cmd_seq.sv
// ============================================================================
// Module  : tb_bitset_cmd_seq
// Brief   : Directed self-checking bench for bitset_cmd_seq (WIDTH=4 and WIDTH=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitset_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  logic       a_valid, a_ready, a_load, a_value, a_hold, a_yv, a_err, a_busy;
  logic [1:0] a_index;
  logic [3:0] a_data, a_y;
  logic [2:0] a_count;

  logic       b_valid, b_ready, b_load, b_value, b_hold, b_yv, b_err, b_busy;
  logic [1:0] b_index;
  logic [2:0] b_data, b_y;
  logic [2:0] b_count;

`ifdef BITSET_PARITY_EN
  logic a_par, b_par;
`endif

  bitset_cmd_seq #(.WIDTH(4), .IDX_W(2), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_load(a_load), .cmd_index(a_index), .cmd_value(a_value), .cmd_data(a_data),
    .hold(a_hold), .y(a_y), .y_valid(a_yv), .idx_err(a_err), .count(a_count),
    .busy(a_busy)
`ifdef BITSET_PARITY_EN
    , .y_parity(a_par)
`endif
  );

  bitset_cmd_seq #(.WIDTH(3), .IDX_W(2), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_load(b_load), .cmd_index(b_index), .cmd_value(b_value), .cmd_data(b_data),
    .hold(b_hold), .y(b_y), .y_valid(b_yv), .idx_err(b_err), .count(b_count),
    .busy(b_busy)
`ifdef BITSET_PARITY_EN
    , .y_parity(b_par)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic ld, input logic [1:0] ix,
                         input logic vl, input logic [3:0] dt);
    a_valid = v; a_load = ld; a_index = ix; a_value = vl; a_data = dt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    a_hold = 1'b0;
    b_valid = 1'b0; b_load = 1'b0; b_index = 2'd0; b_value = 1'b0; b_data = 3'd0; b_hold = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    n_vec++; if (a_y !== 4'b0000) begin n_err++; $display("FAIL reset_y: got %b want 0000", a_y); end
    n_vec++; if (a_yv !== 1'b0 || a_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: y_valid=%b idx_err=%b want 0 0", a_yv, a_err); end
    n_vec++; if (a_count !== 3'd0 || a_busy !== 1'b0) begin n_err++; $display("FAIL reset_count: count=%0d busy=%b want 0 0", a_count, a_busy); end
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", a_ready); end
  endtask

  task automatic test_load();
    drive_a(1'b1, 1'b1, 2'd0, 1'b0, 4'b1100);
    step();
    a_valid = 1'b0;
    n_vec++; if (a_count !== 3'd1 || a_y !== 4'b0000 || a_busy !== 1'b1) begin n_err++; $display("FAIL load_push: count=%0d y=%b busy=%b want 1 0000 1", a_count, a_y, a_busy); end
    step();
    n_vec++; if (a_y !== 4'b1100 || a_yv !== 1'b1) begin n_err++; $display("FAIL load_apply: y=%b y_valid=%b want 1100 1", a_y, a_yv); end
    n_vec++; if (a_err !== 1'b0 || a_count !== 3'd0) begin n_err++; $display("FAIL load_flags: idx_err=%b count=%0d want 0 0", a_err, a_count); end
    step();
    n_vec++; if (a_yv !== 1'b0 || a_y !== 4'b1100) begin n_err++; $display("FAIL load_after: y_valid=%b y=%b want 0 1100", a_yv, a_y); end
  endtask

  task automatic test_back_to_back();
    drive_a(1'b1, 1'b1, 2'd0, 1'b0, 4'b0101);
    step();
    a_valid = 1'b0;
    step(); step();
    n_vec++; if (a_y !== 4'b0101 || a_yv !== 1'b0) begin n_err++; $display("FAIL b2b_setup: y=%b y_valid=%b want 0101 0", a_y, a_yv); end
    drive_a(1'b1, 1'b0, 2'd0, 1'b1, 4'h0);
    step();
    n_vec++; if (a_y !== 4'b0101) begin n_err++; $display("FAIL b2b_c0: y=%b want 0101", a_y); end
    drive_a(1'b1, 1'b0, 2'd2, 1'b0, 4'h0);
    step();
    a_valid = 1'b0;
    n_vec++; if (a_y !== 4'b0101 || a_yv !== 1'b1 || a_count !== 3'd1) begin n_err++; $display("FAIL b2b_c1: y=%b y_valid=%b count=%0d want 0101 1 1", a_y, a_yv, a_count); end
    step();
    n_vec++; if (a_y !== 4'b0001 || a_yv !== 1'b1 || a_count !== 3'd0) begin n_err++; $display("FAIL b2b_c2: y=%b y_valid=%b count=%0d want 0001 1 0", a_y, a_yv, a_count); end
    step();
    n_vec++; if (a_yv !== 1'b0 || a_y !== 4'b0001) begin n_err++; $display("FAIL b2b_idle: y_valid=%b y=%b want 0 0001", a_yv, a_y); end
  endtask

  task automatic test_hold();
    logic       ld [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] ix [4] = '{2'd3, 2'd0, 2'd0, 2'd2};
    logic       vl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] dt [4] = '{4'h0, 4'b0110, 4'h0, 4'h0};
    logic [3:0] ex [4] = '{4'b1001, 4'b0110, 4'b0111, 4'b0011};
    bit got = 1'b0;
    a_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, ld[k], ix[k], vl[k], dt[k]);
      n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL hold_ready_%0d: got %b want 1", k, a_ready); end
      step();
    end
    n_vec++; if (a_count !== 3'd4 || a_ready !== 1'b0) begin n_err++; $display("FAIL hold_full: count=%0d ready=%b want 4 0", a_count, a_ready); end
    drive_a(1'b1, 1'b1, 2'd0, 1'b0, 4'b1111);
    step(); step();
    n_vec++; if (a_count !== 3'd4 || a_y !== 4'b0001 || a_yv !== 1'b0) begin n_err++; $display("FAIL hold_reject: count=%0d y=%b y_valid=%b want 4 0001 0", a_count, a_y, a_yv); end
    a_valid = 1'b0;
    a_hold  = 1'b0;
    for (int t = 0; t < 4 && !got; t++) begin
      step();
      if (a_yv === 1'b1) got = 1'b1;
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL hold_release_timeout: y_valid=%b want 1 within 4 cycles", a_yv); end
    n_vec++; if (a_y !== ex[0] || a_count !== 3'd3 || a_ready !== 1'b1) begin n_err++; $display("FAIL hold_pop0: y=%b count=%0d ready=%b want %b 3 1", a_y, a_count, a_ready, ex[0]); end
    for (int k = 1; k < 4; k++) begin
      step();
      n_vec++; if (a_y !== ex[k] || a_yv !== 1'b1 || a_count !== 3'(3 - k)) begin n_err++; $display("FAIL hold_pop%0d: y=%b y_valid=%b count=%0d want %b 1 %0d", k, a_y, a_yv, a_count, ex[k], 3 - k); end
    end
    step();
    n_vec++; if (a_yv !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin n_err++; $display("FAIL hold_drain: y_valid=%b busy=%b ready=%b want 0 0 1", a_yv, a_busy, a_ready); end
  endtask

  task automatic test_wrap();
    logic       ld [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] ix [10] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic       vl [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] dt [10] = '{4'b1010, 4'h0, 4'h0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'b1111, 4'h0, 4'h0};
    logic [3:0] ex [10] = '{4'b1010, 4'b1000, 4'b1001, 4'b0000, 4'b1000,
                            4'b1100, 4'b0100, 4'b1111, 4'b1101, 4'b1001};
    a_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_a(1'b1, ld[k], ix[k], vl[k], dt[k]);
      step();
    end
    a_valid = 1'b0;
    a_hold  = 1'b0;
    step();
    n_vec++; if (a_count !== 3'd2) begin n_err++; $display("FAIL wrap_prefill: count=%0d want 2", a_count); end
    for (int k = 2; k < 10; k++) begin
      drive_a(1'b1, ld[k], ix[k], vl[k], dt[k]);
      step();
      n_vec++; if (a_y !== ex[k-2] || a_yv !== 1'b1 || a_count !== 3'd2) begin n_err++; $display("FAIL wrap_pushpop%0d: y=%b y_valid=%b count=%0d want %b 1 2", k, a_y, a_yv, a_count, ex[k-2]); end
    end
    a_valid = 1'b0;
    for (int k = 8; k < 10; k++) begin
      step();
      n_vec++; if (a_y !== ex[k] || a_yv !== 1'b1 || a_count !== 3'(9 - k)) begin n_err++; $display("FAIL wrap_drain%0d: y=%b y_valid=%b count=%0d want %b 1 %0d", k, a_y, a_yv, a_count, ex[k], 9 - k); end
    end
    step();
    n_vec++; if (a_yv !== 1'b0 || a_y !== 4'b1001) begin n_err++; $display("FAIL wrap_hold_y: y_valid=%b y=%b want 0 1001", a_yv, a_y); end
  endtask

  task automatic test_idx_err();
    b_valid = 1'b1; b_load = 1'b1; b_data = 3'b101;
    step();
    b_valid = 1'b0;
    step();
    n_vec++; if (b_y !== 3'b101 || b_err !== 1'b0) begin n_err++; $display("FAIL idx_setup: y=%b idx_err=%b want 101 0", b_y, b_err); end
    b_valid = 1'b1; b_load = 1'b0; b_index = 2'd3; b_value = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    n_vec++; if (b_y !== 3'b101 || b_yv !== 1'b1 || b_err !== 1'b1) begin n_err++; $display("FAIL idx_oob: y=%b y_valid=%b idx_err=%b want 101 1 1", b_y, b_yv, b_err); end
    step();
    n_vec++; if (b_yv !== 1'b0 || b_err !== 1'b1 || b_count !== 3'd0) begin n_err++; $display("FAIL idx_sticky: y_valid=%b idx_err=%b count=%0d want 0 1 0", b_yv, b_err, b_count); end
    b_valid = 1'b1; b_index = 2'd1; b_value = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    n_vec++; if (b_y !== 3'b111 || b_err !== 1'b1) begin n_err++; $display("FAIL idx_after: y=%b idx_err=%b want 111 1", b_y, b_err); end
  endtask

`ifdef BITSET_PARITY_EN
  task automatic test_parity();
    drive_a(1'b1, 1'b1, 2'd0, 1'b0, 4'b1100);
    step();
    drive_a(1'b1, 1'b1, 2'd0, 1'b0, 4'b0111);
    step();
    a_valid = 1'b0;
    n_vec++; if (a_y !== 4'b1100 || a_par !== 1'b0) begin n_err++; $display("FAIL parity_1100: y=%b parity=%b want 1100 0", a_y, a_par); end
    step();
    n_vec++; if (a_y !== 4'b0111 || a_par !== 1'b1) begin n_err++; $display("FAIL parity_0111: y=%b parity=%b want 0111 1", a_y, a_par); end
    step();
  endtask
`endif

  task automatic test_async_reset();
    drive_a(1'b1, 1'b1, 2'd0, 1'b0, 4'b1111);
    step();
    a_valid = 1'b0;
    step();
    a_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b1, 1'b1, 2'd0, 1'b0, 4'b0000);
      step();
    end
    a_valid = 1'b0;
    n_vec++; if (a_count !== 3'd3 || a_y !== 4'b1111) begin n_err++; $display("FAIL arst_setup: count=%0d y=%b want 3 1111", a_count, a_y); end
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if (a_y !== 4'b0000 || a_count !== 3'd0 || a_busy !== 1'b0 || a_yv !== 1'b0) begin n_err++; $display("FAIL arst_immediate: y=%b count=%0d busy=%b y_valid=%b want 0000 0 0 0", a_y, a_count, a_busy, a_yv); end
    n_vec++; if (b_err !== 1'b0) begin n_err++; $display("FAIL arst_idx_err: got %b want 0", b_err); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    a_hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++; if (a_y !== 4'b0000 || a_yv !== 1'b0 || a_count !== 3'd0 || a_ready !== 1'b1) begin n_err++; $display("FAIL arst_release%0d: y=%b y_valid=%b count=%0d ready=%b want 0000 0 0 1", k, a_y, a_yv, a_count, a_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_hold();
    test_wrap();
    test_idx_err();
`ifdef BITSET_PARITY_EN
    test_parity();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
